// File: rtl/nes_joypad_pkg.sv
// Shared constants for the NES controller-port bus responder: port addresses,
// open-bus pattern, button bit positions and counter width.
package nes_joypad_pkg;

   localparam logic [15:0] JOY_ADDR_P1 = 16'h4016;
   localparam logic [15:0] JOY_ADDR_P2 = 16'h4017;
   localparam logic [7:0]  OPEN_BUS    = 8'h40;

   localparam int unsigned BTN_A      = 0;
   localparam int unsigned BTN_B      = 1;
   localparam int unsigned BTN_SELECT = 2;
   localparam int unsigned BTN_START  = 3;
   localparam int unsigned BTN_UP     = 4;
   localparam int unsigned BTN_DOWN   = 5;
   localparam int unsigned BTN_LEFT   = 6;
   localparam int unsigned BTN_RIGHT  = 7;

   localparam int unsigned JOY_COUNT_W = 4;
   localparam logic [JOY_COUNT_W-1:0] JOY_COUNT_MAX = JOY_COUNT_W'(8);

endpackage

// File: rtl/joypad_shift_port.sv
// One controller port: parallel-load while strobed, otherwise shifts out one
// button per read with 1s filling from the top; read count saturates at 8.
module joypad_shift_port
   import nes_joypad_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic                   i_clk_en,
   input  logic                   i_load,
   input  logic                   i_shift,
   input  logic [7:0]             i_buttons,
   output logic                   o_serial,
   output logic [JOY_COUNT_W-1:0] o_count
);

   logic [7:0]             shift_q, shift_d;
   logic [JOY_COUNT_W-1:0] count_q, count_d;

   always_comb begin
      shift_d = shift_q;
      count_d = count_q;
      if (i_clk_en) begin
         if (i_load) begin
            shift_d = i_buttons;
            count_d = '0;
         end else if (i_shift) begin
            shift_d = {1'b1, shift_q[7:1]};
            if (count_q < JOY_COUNT_MAX) begin
               count_d = count_q + JOY_COUNT_W'(1);
            end
         end
      end
   end

   // CPU bus state advances on the falling edge of phi2.
   always_ff @(negedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         shift_q <= 8'hFF;
         count_q <= '0;
      end else begin
         shift_q <= shift_d;
         count_q <= count_d;
      end
   end

   // While strobed the A button is seen live rather than the latched copy.
   assign o_serial = i_load ? i_buttons[BTN_A] : shift_q[0];
   assign o_count  = count_q;

endmodule

// File: rtl/joypad_bus_responder.sv
// CPU-bus responder for controller ports $4016/$4017: strobe register, address
// decode and read mux. Define JOYPAD_PORT2_EN to build the port 2 shifter.
module joypad_bus_responder
   import nes_joypad_pkg::*;
#(
   parameter logic [15:0] ADDR_P1  = JOY_ADDR_P1,
   parameter logic [15:0] ADDR_P2  = JOY_ADDR_P2,
   parameter logic [7:0]  OPEN_BUS = nes_joypad_pkg::OPEN_BUS
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_clk_en,
   input  logic [15:0] i_address,
   input  logic        i_rw,
   input  logic [7:0]  i_data,
   input  logic [7:0]  i_buttons_p1,
   input  logic [7:0]  i_buttons_p2,
   output logic [7:0]  o_data,
   output logic        o_data_en
);

   logic strobe_q, strobe_d;
   logic hit_p1, hit_p2, rd_p1, rd_p2, wr_p1;
   logic p1_bit, p2_bit;
   logic [JOY_COUNT_W-1:0] p1_count, p2_count;

   assign hit_p1 = (i_address == ADDR_P1);
   assign hit_p2 = (i_address == ADDR_P2);
   assign rd_p1  = i_rw & hit_p1;
   assign rd_p2  = i_rw & hit_p2;
   assign wr_p1  = ~i_rw & hit_p1;

   always_comb begin
      strobe_d = strobe_q;
      if (i_clk_en && wr_p1) begin
         strobe_d = i_data[0];
      end
   end

   always_ff @(negedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         strobe_q <= 1'b0;
      end else begin
         strobe_q <= strobe_d;
      end
   end

   // Loading keys off the registered strobe, so the edge that clears it still loads.
   joypad_shift_port u_port1 (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clk_en  (i_clk_en),
      .i_load    (strobe_q),
      .i_shift   (rd_p1),
      .i_buttons (i_buttons_p1),
      .o_serial  (p1_bit),
      .o_count   (p1_count)
   );

`ifdef JOYPAD_PORT2_EN
   joypad_shift_port u_port2 (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clk_en  (i_clk_en),
      .i_load    (strobe_q),
      .i_shift   (rd_p2),
      .i_buttons (i_buttons_p2),
      .o_serial  (p2_bit),
      .o_count   (p2_count)
   );
`else
   // No controller on port 2: reads see a 0 in bit 0.
   assign p2_bit   = 1'b0;
   assign p2_count = '0;
   logic unused_buttons_p2;
   assign unused_buttons_p2 = ^i_buttons_p2;
`endif

   logic unused_sigs;
   assign unused_sigs = ^{i_data[7:1], p1_count, p2_count};

   always_comb begin
      o_data    = 8'h00;
      o_data_en = 1'b0;
      if (rd_p1) begin
         o_data    = OPEN_BUS | {7'b0, p1_bit};
         o_data_en = 1'b1;
      end else if (rd_p2) begin
         o_data    = OPEN_BUS | {7'b0, p2_bit};
         o_data_en = 1'b1;
      end
   end

endmodule

// File: tb/tb_joypad_bus_responder.sv
// Self-checking bench for joypad_bus_responder: directed scenarios with literal
// expectations plus randomized bus traffic against an index-based button model.
module tb_joypad_bus_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clk_en = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic        rw = 1'b1;
   logic [7:0]  wdata = 8'h00;
   logic [7:0]  btn1 = 8'h00;
   logic [7:0]  btn2 = 8'h00;
   logic [7:0]  o_data;
   logic        o_data_en;

   int checks = 0;
   int errors = 0;

   joypad_bus_responder dut (
      .i_clk        (clk),
      .i_reset_n    (rst_n),
      .i_clk_en     (clk_en),
      .i_address    (addr),
      .i_rw         (rw),
      .i_data       (wdata),
      .i_buttons_p1 (btn1),
      .i_buttons_p2 (btn2),
      .o_data       (o_data),
      .o_data_en    (o_data_en)
   );

   always #5 clk = ~clk;

   // Model: latched button byte plus number of reads consumed per port.
   bit       m_strobe = 1'b0;
   bit [7:0] m_lat1 = 8'hFF;
   bit [7:0] m_lat2 = 8'hFF;
   int       m_cnt1 = 0;
   int       m_cnt2 = 0;

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_strobe <= 1'b0;
         m_lat1   <= 8'hFF;
         m_lat2   <= 8'hFF;
         m_cnt1   <= 0;
         m_cnt2   <= 0;
      end else if (clk_en) begin
         if (m_strobe) begin
            m_lat1 <= btn1;
            m_lat2 <= btn2;
            m_cnt1 <= 0;
            m_cnt2 <= 0;
         end else begin
            if (rw && addr == 16'h4016 && m_cnt1 < 8) m_cnt1 <= m_cnt1 + 1;
            if (rw && addr == 16'h4017 && m_cnt2 < 8) m_cnt2 <= m_cnt2 + 1;
         end
         if (!rw && addr == 16'h4016) m_strobe <= wdata[0];
      end
   end

   function automatic bit port_bit(input bit [7:0] lat, input int cnt, input bit [7:0] live);
      if (m_strobe) return live[0];
      if (cnt >= 8) return 1'b1;
      return lat[cnt];
   endfunction

   function automatic logic [8:0] model_out();
      if (rw && addr == 16'h4016) return {1'b1, 7'h20, port_bit(m_lat1, m_cnt1, btn1)};
`ifdef JOYPAD_PORT2_EN
      if (rw && addr == 16'h4017) return {1'b1, 7'h20, port_bit(m_lat2, m_cnt2, btn2)};
`else
      if (rw && addr == 16'h4017) return {1'b1, 8'h40};
`endif
      return 9'h000;
   endfunction

   task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got en=%b data=%h, expected en=%b data=%h",
                  name, $time, act[8], act[7:0], exp[8], exp[7:0]);
      end
   endtask

   // Outputs are checked mid-cycle: after inputs settle, before the falling edge.
   always @(posedge clk) begin
      #3;
      chk("model", {o_data_en, o_data}, model_out());
   end

   task automatic cyc(input logic [15:0] a, input logic r, input logic [7:0] d, input logic en);
      @(posedge clk);
      #1;
      addr = a; rw = r; wdata = d; clk_en = en;
   endtask

   task automatic rd_lit(input string name, input logic [15:0] a, input logic [7:0] exp,
                         input logic en);
      cyc(a, 1'b1, 8'h00, en);
      #2;
      chk(name, {o_data_en, o_data}, {1'b1, exp});
   endtask

   task automatic strobe_pulse();
      cyc(16'h4016, 1'b0, 8'h01, 1'b1);
      cyc(16'h4016, 1'b0, 8'h00, 1'b1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0; addr = 16'h0000; rw = 1'b1; clk_en = 1'b1;
      #2;
      chk("reset_idle", {o_data_en, o_data}, 9'h000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   logic [7:0] exp_p2;

   initial begin
`ifdef JOYPAD_PORT2_EN
      exp_p2 = 8'h41;
`else
      exp_p2 = 8'h40;
`endif
      do_reset();

      // 1: unstrobed read after reset sees all-ones register
      rd_lit("t1_reset_read", 16'h4016, 8'h41, 1'b1);

      // 2: sequence A,B,...,Right then exhausted 1s
      btn1 = 8'b0000_0101;
      strobe_pulse();
      begin
         logic [9:0] seq;
         seq = 10'b11_0000_0101;
         for (int i = 0; i < 10; i++)
            rd_lit("t2_serial", 16'h4016, 8'h40 | {7'b0, seq[i]}, 1'b1);
      end

      // 3: strobe held, A tracked live
      cyc(16'h4016, 1'b0, 8'h01, 1'b1);
      btn1 = 8'h00;
      rd_lit("t3_live_a0", 16'h4016, 8'h40, 1'b1);
      rd_lit("t3_live_a0b", 16'h4016, 8'h40, 1'b1);
      btn1 = 8'h01;
      rd_lit("t3_live_a1", 16'h4016, 8'h41, 1'b1);
      cyc(16'h4016, 1'b0, 8'h00, 1'b1);
      rd_lit("t3_first_after", 16'h4016, 8'h41, 1'b1);
      rd_lit("t3_second_after", 16'h4016, 8'h40, 1'b1);

      // 4: independent ports; $4017 write must not touch strobe
      btn1 = 8'h80; btn2 = 8'h01;
      strobe_pulse();
      cyc(16'h4017, 1'b0, 8'h01, 1'b1);
      for (int i = 0; i < 8; i++) begin
         rd_lit("t4_p1", 16'h4016, (i == 7) ? 8'h41 : 8'h40, 1'b1);
         rd_lit("t4_p2", 16'h4017, (i == 0) ? exp_p2 : 8'h40, 1'b1);
      end

      // 5: disabled edges do not shift
      btn1 = 8'h02;
      strobe_pulse();
      for (int i = 0; i < 5; i++) rd_lit("t5_noen", 16'h4016, 8'h40, 1'b0);
      rd_lit("t5_first", 16'h4016, 8'h40, 1'b1);
      rd_lit("t5_second", 16'h4016, 8'h41, 1'b1);

      // 6: reset mid-sequence
      btn1 = 8'h00;
      strobe_pulse();
      for (int i = 0; i < 3; i++) rd_lit("t6_pre", 16'h4016, 8'h40, 1'b1);
      do_reset();
      rd_lit("t6_after_reset", 16'h4016, 8'h41, 1'b1);
      rd_lit("t6_p2_after_reset", 16'h4017, exp_p2, 1'b1);
      cyc(16'h1234, 1'b1, 8'h00, 1'b1);
      #2;
      chk("t6_miss", {o_data_en, o_data}, 9'h000);

      // Random traffic checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] a;
         case ($urandom_range(0, 4))
            0, 1: a = 16'h4016;
            2, 3: a = 16'h4017;
            default: a = 16'($urandom());
         endcase
         if ($urandom_range(0, 15) == 0) btn1 = 8'($urandom());
         if ($urandom_range(0, 15) == 0) btn2 = 8'($urandom());
         cyc(a, ($urandom_range(0, 3) != 0), 8'($urandom()), ($urandom_range(0, 3) != 0));
         if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
         else rst_n = 1'b1;
      end

      @(posedge clk);
      #4;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
